// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-Lite interconnect widths, response codes and read-mux state type
package axil_pkg;
  localparam int NUMBER_MASTER = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int IDX_WIDTH = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, ADDR, ISSUE, DATA} state_t;
endpackage

// File: rtl/axil_onehot_to_bin.sv
// axil_onehot_to_bin: one-hot legality check and binary index encoder for arbiter grants
module axil_onehot_to_bin #(
  parameter int NUMBER_MASTER = 4,
  parameter int IDX_WIDTH = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1
) (
  input  logic [NUMBER_MASTER-1:0] onehot,
  output logic [IDX_WIDTH-1:0]     index,
  output logic                     valid_onehot
);
  // OR together the positions of set bits; only meaningful when valid_onehot is high
  always_comb begin
    index = '0;
    for (int i = 0; i < NUMBER_MASTER; i++) index = onehot[i] ? (index | IDX_WIDTH'(i)) : index;
  end
  assign valid_onehot = (onehot != '0) && ((onehot & (onehot - NUMBER_MASTER'(1))) == '0);
endmodule

// File: rtl/axil_mux_rd.sv
// axil_mux_rd: read-channel mux routing one granted master's AR/R beats to the single slave
module axil_mux_rd
  import axil_pkg::*;
(
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic [NUMBER_MASTER-1:0]                 grant_rd,
  input  logic [NUMBER_MASTER-1:0][ADDR_WIDTH-1:0] m_axil_araddr,
  input  logic [NUMBER_MASTER-1:0]                 m_axil_arvalid,
  output logic [NUMBER_MASTER-1:0]                 m_axil_arready,
  output logic [NUMBER_MASTER-1:0][DATA_WIDTH-1:0] m_axil_rdata,
  output logic [NUMBER_MASTER-1:0][1:0]            m_axil_rresp,
  output logic [NUMBER_MASTER-1:0]                 m_axil_rvalid,
  input  logic [NUMBER_MASTER-1:0]                 m_axil_rready,
  output logic [ADDR_WIDTH-1:0]                    s_axil_araddr,
  output logic                                     s_axil_arvalid,
  input  logic                                     s_axil_arready,
  input  logic [DATA_WIDTH-1:0]                    s_axil_rdata,
  input  logic [1:0]                               s_axil_rresp,
  input  logic                                     s_axil_rvalid,
  output logic                                     s_axil_rready,
  output logic                                     busy_rd
);
  state_t                 r_state, w_next;
  logic [IDX_WIDTH-1:0]   r_idx, w_grant_idx;
  logic [ADDR_WIDTH-1:0]  r_ar_addr;
  logic                   r_arvalid, w_grant_ok;

  axil_onehot_to_bin #(.NUMBER_MASTER(NUMBER_MASTER), .IDX_WIDTH(IDX_WIDTH)) u_enc (
    .onehot       (grant_rd),
    .index        (w_grant_idx),
    .valid_onehot (w_grant_ok)
  );

  // state register; reset aborts any transaction in flight
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_state <= IDLE;
    else r_state <= w_next;

  // next state: grant sampled only in IDLE, later steps follow the latched index
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_grant_ok ? ADDR : IDLE;
      ADDR:  w_next = m_axil_arvalid[r_idx] ? ISSUE : ADDR;
      ISSUE: w_next = s_axil_arready ? DATA : ISSUE;
      DATA:  w_next = (s_axil_rvalid && m_axil_rready[r_idx]) ? IDLE : DATA;
      default: w_next = IDLE;
    endcase
  end

  // latched index, captured address and registered slave AR valid
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_idx     <= '0;
      r_ar_addr <= '0;
      r_arvalid <= 1'b0;
    end else begin
      if (r_state == IDLE && w_grant_ok) r_idx <= w_grant_idx;
      if (r_state == ADDR && m_axil_arvalid[r_idx]) begin
        r_ar_addr <= m_axil_araddr[r_idx];
        r_arvalid <= 1'b1;
      end else if (r_state == ISSUE && s_axil_arready) r_arvalid <= 1'b0;
    end

  // outputs: arready in ADDR, zero-latency R route in DATA, everything else quiet
  always_comb begin
    m_axil_arready = '0;
    m_axil_rvalid  = '0;
    m_axil_rdata   = '0;
    m_axil_rresp   = '0;
    s_axil_rready  = 1'b0;
    if (r_state == ADDR) m_axil_arready[r_idx] = 1'b1;
    if (r_state == DATA) begin
      m_axil_rvalid[r_idx] = s_axil_rvalid;
      m_axil_rdata[r_idx]  = s_axil_rdata;
      m_axil_rresp[r_idx]  = s_axil_rresp;
      s_axil_rready        = m_axil_rready[r_idx];
    end
  end

  assign s_axil_araddr  = r_ar_addr;
  assign s_axil_arvalid = r_arvalid;
  assign busy_rd        = r_state != IDLE;

  a_grant_onehot: assert property (@(posedge aclk) disable iff (!aresetn)
    r_state != IDLE || $onehot0(grant_rd))
    else $warning("axil_mux_rd: multi-bit grant_rd ignored");
endmodule

// File: tb/tb_axil_mux_rd.sv
// tb_axil_mux_rd: table-driven reads with an AR/R scoreboard plus hand-written corner sequences
module tb_axil_mux_rd;
  import axil_pkg::*;

  logic                                     aclk = 1'b0;
  logic                                     aresetn;
  logic [NUMBER_MASTER-1:0]                 grant_rd;
  logic [NUMBER_MASTER-1:0][ADDR_WIDTH-1:0] m_axil_araddr;
  logic [NUMBER_MASTER-1:0]                 m_axil_arvalid;
  logic [NUMBER_MASTER-1:0]                 m_axil_arready;
  logic [NUMBER_MASTER-1:0][DATA_WIDTH-1:0] m_axil_rdata;
  logic [NUMBER_MASTER-1:0][1:0]            m_axil_rresp;
  logic [NUMBER_MASTER-1:0]                 m_axil_rvalid;
  logic [NUMBER_MASTER-1:0]                 m_axil_rready;
  logic [ADDR_WIDTH-1:0]                    s_axil_araddr;
  logic                                     s_axil_arvalid;
  logic                                     s_axil_arready;
  logic [DATA_WIDTH-1:0]                    s_axil_rdata;
  logic [1:0]                               s_axil_rresp;
  logic                                     s_axil_rvalid;
  logic                                     s_axil_rready;
  logic                                     busy_rd;

  axil_mux_rd dut (
    .aclk(aclk), .aresetn(aresetn), .grant_rd(grant_rd),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready), .busy_rd(busy_rd)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]  grant;
    logic [3:0]  chg;
    int          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    int          ar_stall;
    int          r_stall;
  } vec_t;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic [1:0]  resp;
  } r_t;

  vec_t        vecs[6];
  logic [31:0] exp_ar[$];
  r_t          exp_r[$];
  int          checks = 0, passes = 0, n_ar = 0, n_r = 0, ar_cnt = 0, r_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // scoreboard monitor: AR/R handshakes and AR hold stability, sampled mid-cycle
  always @(negedge aclk) begin
    if (!aresetn) pend = 1'b0;
    else begin
      if (pend) begin
        chk("ar_valid_hold", s_axil_arvalid, 1);
        chk("ar_addr_hold", s_axil_araddr, pend_addr);
      end
      pend = s_axil_arvalid && !s_axil_arready;
      pend_addr = s_axil_araddr;
      if (s_axil_arvalid && s_axil_arready) begin
        ar_cnt++;
        if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
        else chk("ar_beat_addr", s_axil_araddr, exp_ar.pop_front());
      end
      if (|(m_axil_rvalid & m_axil_rready)) begin
        r_t e;
        r_cnt++;
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          e = exp_r.pop_front();
          chk("r_beat_rvalid", m_axil_rvalid, 64'(1) << e.m);
          chk("r_beat_data", m_axil_rdata[e.m], e.data);
          chk("r_beat_resp", m_axil_rresp[e.m], e.resp);
        end
      end
    end
  end

  task automatic idle_inputs();
    grant_rd = '0; m_axil_arvalid = '0; m_axil_rready = '0; m_axil_araddr = '0;
    s_axil_arready = 1'b0; s_axil_rvalid = 1'b0; s_axil_rdata = '0; s_axil_rresp = '0;
  endtask

  // one full read starting in an IDLE cycle, just after a rising edge
  task automatic run(input vec_t v);
    grant_rd = v.grant;
    m_axil_araddr[v.m] = v.addr;
    m_axil_arvalid[v.m] = 1'b1;
    exp_ar.push_back(v.addr);
    exp_r.push_back('{v.m, v.data, v.resp});
    n_ar++; n_r++;
    @(posedge aclk); #1;
    chk("addr_arready", m_axil_arready, 64'(1) << v.m);
    chk("addr_busy", busy_rd, 1);
    @(posedge aclk); #1;
    m_axil_arvalid = '0;
    chk("issue_arvalid", s_axil_arvalid, 1);
    chk("issue_araddr", s_axil_araddr, v.addr);
    chk("issue_arready_off", m_axil_arready, 0);
    if (v.chg != '0) begin
      grant_rd = v.chg;
      m_axil_arvalid = v.chg;
    end
    repeat (v.ar_stall) begin
      @(posedge aclk); #1;
      chk("stall_arvalid", s_axil_arvalid, 1);
      chk("stall_arready_off", m_axil_arready, 0);
    end
    s_axil_arready = 1'b1;
    @(posedge aclk); #1;
    s_axil_arready = 1'b0;
    chk("data_arvalid_off", s_axil_arvalid, 0);
    s_axil_rvalid = 1'b1; s_axil_rdata = v.data; s_axil_rresp = v.resp;
    repeat (v.r_stall) begin
      #1;
      chk("rstall_rready", s_axil_rready, 0);
      chk("rstall_rvalid", m_axil_rvalid, 64'(1) << v.m);
      chk("rstall_arready_off", m_axil_arready, 0);
      @(posedge aclk); #1;
    end
    m_axil_rready[v.m] = 1'b1;
    #1;
    chk("r_rready", s_axil_rready, 1);
    chk("r_data_route", m_axil_rdata[v.m], v.data);
    chk("r_resp_route", m_axil_rresp[v.m], v.resp);
    @(posedge aclk); #1;
    idle_inputs();
    chk("done_idle", busy_rd, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'b0010, 4'b0000, 1, 32'h0000_1000, 32'hDEAD_BEEF, RESP_OKAY,   0, 0};
    vecs[1] = '{4'b0001, 4'b0000, 0, 32'h0000_2004, 32'h1234_5678, RESP_OKAY,   5, 3};
    vecs[2] = '{4'b1000, 4'b0000, 3, 32'hFFFF_FFFC, 32'h0000_0000, RESP_SLVERR, 0, 0};
    vecs[3] = '{4'b0100, 4'b0000, 2, 32'h0000_0000, 32'hFFFF_FFFF, 2'b11,       1, 1};
    vecs[4] = '{4'b0010, 4'b1000, 1, 32'h0000_3008, 32'hCAFE_F00D, RESP_OKAY,   2, 1};
    vecs[5] = '{4'b0001, 4'b0000, 0, 32'h0000_4000, 32'hA5A5_5A5A, RESP_OKAY,   0, 0};
    idle_inputs();
    aresetn = 1'b0;
    #12;
    chk("rst_busy", busy_rd, 0);
    chk("rst_arvalid", s_axil_arvalid, 0);
    chk("rst_araddr", s_axil_araddr, 0);
    chk("rst_arready", m_axil_arready, 0);
    chk("rst_rvalid", m_axil_rvalid, 0);
    chk("rst_rready", s_axil_rready, 0);
    chk("rst_rdata", m_axil_rdata, 0);
    chk("rst_rresp", m_axil_rresp, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    for (int i = 0; i < 5; i++) run(vecs[i]);
    grant_rd = 4'b0110;
    m_axil_arvalid = 4'b0110;
    repeat (3) begin
      @(posedge aclk); #1;
      chk("illegal_busy", busy_rd, 0);
      chk("illegal_arready", m_axil_arready, 0);
      chk("illegal_arvalid", s_axil_arvalid, 0);
    end
    idle_inputs();
    @(posedge aclk); #1;
    grant_rd = 4'b0001;
    m_axil_araddr[0] = 32'h0000_0ABC;
    m_axil_arvalid[0] = 1'b1;
    s_axil_arready = 1'b1;
    exp_ar.push_back(32'h0000_0ABC);
    n_ar++;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    m_axil_arvalid = '0;
    @(posedge aclk); #1;
    s_axil_arready = 1'b0;
    s_axil_rvalid = 1'b1; s_axil_rdata = 32'h1111_2222; m_axil_rready[0] = 1'b1;
    #1;
    chk("pre_rst_rready", s_axil_rready, 1);
    aresetn = 1'b0;
    #1;
    chk("arst_arvalid", s_axil_arvalid, 0);
    chk("arst_rready", s_axil_rready, 0);
    chk("arst_arready", m_axil_arready, 0);
    chk("arst_rvalid", m_axil_rvalid, 0);
    chk("arst_busy", busy_rd, 0);
    idle_inputs();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    run(vecs[5]);
    repeat (2) @(posedge aclk);
    #1;
    chk("ar_queue_empty", exp_ar.size(), 0);
    chk("r_queue_empty", exp_r.size(), 0);
    chk("ar_beat_count", ar_cnt, n_ar);
    chk("r_beat_count", r_cnt, n_r);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
